// File: rtl/seg_scan_ctrl_if.sv
// Bus bundle between a display-data source and the 4-digit scan controller.
interface seg_scan_ctrl_if;
  logic        load;
  logic [15:0] bcd_in;
  logic        lzb;
  logic [3:0]  bcd_out;
  logic [3:0]  an;
  logic        pending;

  modport master (
    output load, bcd_in, lzb,
    input  bcd_out, an, pending
  );

  modport slave (
    input  load, bcd_in, lzb,
    output bcd_out, an, pending
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Four-digit 7-segment scan controller: time-multiplexes one BCD decoder
// across four anodes, with a shadow register that is transferred to the
// visible digits only at frame boundaries, plus optional leading-zero blanking.
module seg_scan_ctrl #(
  parameter int unsigned DIV   = 1000,
  parameter int unsigned BLANK = 2
) (
  input  logic           clk,
  input  logic           rst,
  seg_scan_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      shadow;
  logic [15:0]      display;
  logic             pending;

  logic             slot_end;
  logic             frame_end;
  logic             in_blank;
  logic [3:0]       digit;
  logic             z3, z2, z1;
  logic             lz_blank;

  assign slot_end  = (cnt == CNT_W'(DIV - 1));
  assign frame_end = slot_end && (idx == 2'd3);

  // Anodes are held off for the first BLANK cycles of each slot to hide ghosting.
  generate
    if (BLANK == 0) begin : g_noblank
      assign in_blank = 1'b0;
    end else begin : g_blank
      assign in_blank = (cnt < CNT_W'(BLANK));
    end
  endgenerate

  // Slot/digit counters, shadow capture and frame-aligned display transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= 2'd0;
      shadow  <= 16'h0000;
      display <= 16'h0000;
      pending <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end)
        idx <= idx + 2'd1;
      // Display takes the pre-edge shadow, so a coincident load still pends.
      if (frame_end && pending)
        display <= shadow;
      if (bus.load) begin
        shadow  <= bus.bcd_in;
        pending <= 1'b1;
      end else if (frame_end) begin
        pending <= 1'b0;
      end
    end
  end

  // Select the digit currently being scanned.
  always_comb begin
    digit = display[3:0];
    case (idx)
      2'd0: digit = display[3:0];
      2'd1: digit = display[7:4];
      2'd2: digit = display[11:8];
      2'd3: digit = display[15:12];
      default: digit = display[3:0];
    endcase
  end

  // A digit is a leading zero when it and every more significant digit is zero.
  always_comb begin
    z3       = (display[15:12] == 4'h0);
    z2       = z3 && (display[11:8] == 4'h0);
    z1       = z2 && (display[7:4] == 4'h0);
    lz_blank = 1'b0;
    case (idx)
      2'd1: lz_blank = z1;
      2'd2: lz_blank = z2;
      2'd3: lz_blank = z3;
      default: lz_blank = 1'b0;
    endcase
  end

  // Drive decoder code and one-hot anode from registered state and lzb only.
  always_comb begin
    bus.bcd_out = (bus.lzb && lz_blank) ? 4'hF : digit;
    bus.an      = 4'b0000;
    if (!in_blank)
      bus.an[idx] = 1'b1;
    bus.pending = pending;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The module SHALL have parameter DIV, default 1000, clock cycles per digit slot (legal range 2..65535).
REQ-002 The module SHALL have parameter BLANK, default 2, cycles at the start of each slot with all anodes off (legal range 0..DIV-1).
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 load  input  1  one-cycle strobe; captures bcd_in into the shadow register.
REQ-006 bcd_in  input  16  four BCD digits: [15:12] digit 3 (MSD) ... [3:0] digit 0 (LSD).
REQ-007 lzb  input  1  leading-zero blanking enable, sampled every cycle.
REQ-008 bcd_out  output  4  BCD code to the shared 7-segment decoder; 4'hF = blank (decoder default, all segments off).
REQ-009 an  output  4  one-hot active-high digit enable; an[i] selects digit i.
REQ-010 pending  output  1  shadow holds data not yet shown.

Function
REQ-011 The block SHALL time-multiplex one decoder across four digits: slot counter cnt counts 0..DIV-1; digit index idx advances 0->1->2->3->0 when cnt==DIV-1, with cnt wrapping to 0.
REQ-012 an SHALL be 4'b0000 while cnt<BLANK, else one-hot at position idx; never more than one bit high.
REQ-013 bcd_out SHALL equal display digit idx, except forced to 4'hF when blanked per REQ-014; codes 10..15 pass unchanged (decoder blanks them).
REQ-014 With lzb=1, digit i (i=3,2,1) SHALL be blanked when display digits i..3 are all zero; digit 0 is never blanked; lzb=0 disables blanking.
REQ-015 bcd_out and an SHALL be combinational functions of registered state (cnt, idx, display) and lzb only; bcd_in and load SHALL NOT affect them combinationally.
REQ-016 load=1 SHALL write bcd_in into shadow and set pending=1 on the same edge; a later load before transfer overwrites shadow (last write wins).
REQ-017 Frame boundary = edge with idx==3 and cnt==DIV-1; at that edge, if pending=1, display SHALL take shadow and pending SHALL clear.
REQ-018 load coincident with a frame boundary: display SHALL take the old shadow, shadow takes bcd_in, pending SHALL remain 1.
REQ-019 display SHALL change only at frame boundaries (no mid-frame tearing); load with pending=0 therefore shows from the next frame onward.
REQ-020 Frame period SHALL be exactly 4*DIV cycles; anode on-time per digit SHALL be DIV-BLANK cycles.
REQ-021 cnt width SHALL be the minimum to hold DIV-1; no other state beyond cnt, idx, shadow, display, pending.

Reset
REQ-022 rst=1 SHALL immediately (no clock) set cnt=0, idx=0, shadow=16'h0000, display=16'h0000, pending=0.
REQ-023 Consequent outputs during/after reset: an=4'b0000 if BLANK>0 else 4'b0001; bcd_out=4'h0 (lzb=0) or 4'h0 for digit 0 (lzb never blanks digit 0).
REQ-024 Reset asserted mid-frame or with pending=1 SHALL discard shadow contents; first slot after release is digit 0 with cnt=0.
REQ-025 Release SHALL take effect on the first rising clk edge after rst falls; load on that edge is honoured.

Verification (DIV=4, BLANK=1 unless noted)
REQ-026 Reset then free-run 16 cycles -> an sequence per slot 0000,0001,0001,0001 then 0000,0010x3 ... 1000x3; idx back to 0 at cycle 16; bcd_out=0 throughout.
REQ-027 load bcd_in=16'h1234 at cycle 2, lzb=0 -> pending=1 cycles 3..15; digits 0 until frame edge at cycle 15; next frame bcd_out 4,3,2,1 with an 0001,0010,0100,1000; pending=0.
REQ-028 display 16'h0045, lzb=1 -> digits 3,2 show bcd_out=4'hF, digits 1,0 show 4,5; lzb=0 -> 0,0,4,5; display 16'h0000, lzb=1 -> F,F,F,0.
REQ-029 load 16'hAAAA then 16'h5678 before boundary -> next frame shows 8,7,6,5; load 16'h9999 on exact boundary edge -> display gets prior shadow, pending stays 1, 9999 shows one frame later.
REQ-030 pending=1 and idx=2, assert rst asynchronously between edges -> outputs reset immediately, pending=0, display stays 0000 after release.
REQ-031 DIV=3, BLANK=0 -> an never 0000 after reset, each bit high exactly 3 cycles, frame 12 cycles.
